// File: rtl/alu_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_controller
// Description : EX-stage ALU controller. Decodes ALUOp/Funct3/Funct7 into the
//               4-bit ALU select for the full RV32I set and flags unsupported
//               encodings. It also sequences RV32M multiply/divide operations
//               through an external iterative unit and holds the pipeline
//               until the result is ready.
//
// Parameters  : EN_M     1 = RV32M ops are sequenced, 0 = reported illegal
//               MUL_LAT  busy cycles for MUL/MULH/MULHSU/MULHU (1..255)
//               DIV_LAT  busy cycles for DIV/DIVU/REM/REMU     (1..255)
//
// Ports       : clk          in   clock, rising edge
//               reset        in   synchronous, active-high
//               ALUOp        in   [1:0] 00 ld/st/auipc, 01 branch,
//                                       10 R-type, 11 I-type ALU
//               Funct7       in   [6:0] instr[31:25]
//               Funct3       in   [2:0] instr[14:12]
//               instr_valid  in   EX holds a valid instruction
//               flush        in   kill EX instruction, abort M op
//               div_by_zero  in   rs2 == 0, sampled at M-op start
//               Operation    out  [3:0] ALU select (combinational)
//               illegal      out  unsupported encoding (combinational)
//               md_start     out  one-cycle start pulse to mul/div unit
//               md_op        out  [2:0] M-op funct3
//               md_busy      out  sequencer in BUSY
//               md_done      out  one-cycle result-valid pulse
//               md_dz        out  qualifies md_done: divide-by-zero result
//               stall        out  freeze IF/ID/EX
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_controller #(
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ALUOp,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       instr_valid,
    input  logic       flush,
    input  logic       div_by_zero,
    output logic [3:0] Operation,
    output logic       illegal,
    output logic       md_start,
    output logic [2:0] md_op,
    output logic       md_busy,
    output logic       md_done,
    output logic       md_dz,
    output logic       stall
);

    // ------------------------------------------------------------------
    // ALU operation encodings
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_AND  = 4'b0000;
    localparam logic [3:0] c_OP_OR   = 4'b0001;
    localparam logic [3:0] c_OP_ADD  = 4'b0010;
    localparam logic [3:0] c_OP_XOR  = 4'b0011;
    localparam logic [3:0] c_OP_SLL  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_SUB  = 4'b0110;
    localparam logic [3:0] c_OP_SRA  = 4'b0111;
    localparam logic [3:0] c_OP_BEQ  = 4'b1000;
    localparam logic [3:0] c_OP_BNE  = 4'b1001;
    localparam logic [3:0] c_OP_BGE  = 4'b1010;
    localparam logic [3:0] c_OP_BLT  = 4'b1011;
    localparam logic [3:0] c_OP_SLT  = 4'b1100;
    localparam logic [3:0] c_OP_SLTU = 4'b1101;
    localparam logic [3:0] c_OP_BLTU = 4'b1110;
    localparam logic [3:0] c_OP_BGEU = 4'b1111;

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;
    localparam logic [6:0] c_F7_MEXT = 7'b0000001;

    // Counter preload: the op spends exactly LAT cycles in BUSY, leaving
    // BUSY on the cycle the counter reads zero.
    localparam logic [7:0] c_MUL_CNT = 8'(MUL_LAT - 1);
    localparam logic [7:0] c_DIV_CNT = 8'(DIV_LAT - 1);

    localparam logic c_M_ENABLED = (EN_M != 0);

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;
    logic [2:0] r_md_op;
    logic [2:0] w_md_op_nxt;
    logic       r_dz;
    logic       w_dz_nxt;

    logic [3:0] w_op;
    logic       w_ill_enc;
    logic       w_is_m;
    logic       w_start;
    logic       w_stall;
    logic       w_done;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    always_comb begin
        w_op      = c_OP_ADD;
        w_ill_enc = 1'b0;
        w_is_m    = 1'b0;

        case (ALUOp)
            2'b00: w_op = c_OP_ADD;

            2'b01: begin
                case (Funct3)
                    3'b000:  w_op = c_OP_BEQ;
                    3'b001:  w_op = c_OP_BNE;
                    3'b100:  w_op = c_OP_BLT;
                    3'b101:  w_op = c_OP_BGE;
                    3'b110:  w_op = c_OP_BLTU;
                    3'b111:  w_op = c_OP_BGEU;
                    default: w_ill_enc = 1'b1;
                endcase
            end

            2'b10: begin
                if (Funct7 == c_F7_MEXT) begin
                    // Every Funct3 is a valid RV32M op; ALU select is unused.
                    if (c_M_ENABLED) begin
                        w_is_m = 1'b1;
                    end else begin
                        w_ill_enc = 1'b1;
                    end
                end else begin
                    case (Funct3)
                        3'b000: begin
                            if (Funct7 == c_F7_BASE)     w_op = c_OP_ADD;
                            else if (Funct7 == c_F7_ALT) w_op = c_OP_SUB;
                            else                         w_ill_enc = 1'b1;
                        end
                        3'b101: begin
                            if (Funct7 == c_F7_BASE)     w_op = c_OP_SRL;
                            else if (Funct7 == c_F7_ALT) w_op = c_OP_SRA;
                            else                         w_ill_enc = 1'b1;
                        end
                        default: begin
                            if (Funct7 != c_F7_BASE) begin
                                w_ill_enc = 1'b1;
                            end else begin
                                case (Funct3)
                                    3'b001:  w_op = c_OP_SLL;
                                    3'b010:  w_op = c_OP_SLT;
                                    3'b011:  w_op = c_OP_SLTU;
                                    3'b100:  w_op = c_OP_XOR;
                                    3'b110:  w_op = c_OP_OR;
                                    default: w_op = c_OP_AND;
                                endcase
                            end
                        end
                    endcase
                end
            end

            default: begin
                // I-type: Funct7 carries immediate bits except for shifts.
                case (Funct3)
                    3'b000: w_op = c_OP_ADD;
                    3'b001: begin
                        if (Funct7 == c_F7_BASE) w_op = c_OP_SLL;
                        else                     w_ill_enc = 1'b1;
                    end
                    3'b010: w_op = c_OP_SLT;
                    3'b011: w_op = c_OP_SLTU;
                    3'b100: w_op = c_OP_XOR;
                    3'b101: begin
                        if (Funct7 == c_F7_BASE)     w_op = c_OP_SRL;
                        else if (Funct7 == c_F7_ALT) w_op = c_OP_SRA;
                        else                         w_ill_enc = 1'b1;
                    end
                    3'b110:  w_op = c_OP_OR;
                    default: w_op = c_OP_AND;
                endcase
            end
        endcase

        // Illegal encodings fall back to a harmless ADD.
        if (w_ill_enc) begin
            w_op = c_OP_ADD;
        end
    end

    assign Operation = w_op;
    assign illegal   = instr_valid & w_ill_enc;

    // ------------------------------------------------------------------
    // Mul/div sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_md_op <= 3'b000;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_md_op <= w_md_op_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Mul/div sequencer: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_md_op_nxt = r_md_op;
        w_dz_nxt    = r_dz;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (instr_valid && w_is_m && !flush) begin
                    w_start     = 1'b1;
                    w_stall     = 1'b1;
                    w_md_op_nxt = Funct3;
                    if (Funct3[2] && div_by_zero) begin
                        // Divide by zero needs no iteration: the datapath
                        // writes the architectural result directly.
                        w_state_nxt = S_DONE;
                        w_dz_nxt    = 1'b1;
                        w_cnt_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = S_BUSY;
                        w_dz_nxt    = 1'b0;
                        w_cnt_nxt   = Funct3[2] ? c_DIV_CNT : c_MUL_CNT;
                    end
                end
            end

            S_BUSY: begin
                if (flush) begin
                    // The instruction is being killed, so let the pipeline
                    // move on in the same cycle.
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 8'd0;
                    w_dz_nxt    = 1'b0;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == 8'd0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt - 8'd1;
                    end
                end
            end

            S_DONE: begin
                // The same M instruction is still presented here; returning
                // to IDLE without a start keeps it from being re-issued.
                w_state_nxt = S_IDLE;
                w_dz_nxt    = 1'b0;
                w_done      = !flush;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 8'd0;
                w_dz_nxt    = 1'b0;
            end
        endcase
    end

    // Reset wins over everything in the cycle it is asserted.
    assign md_start = w_start & ~reset;
    assign stall    = w_stall & ~reset;
    assign md_done  = w_done  & ~reset;
    assign md_dz    = md_done & r_dz;
    assign md_busy  = (r_state == S_BUSY);
    // Funct3 is forwarded directly in the start cycle, before it is latched.
    assign md_op    = md_start ? Funct3 : r_md_op;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_controller
// Description : Self-checking bench for alu_seq_controller. A table of decode
//               vectors plus directed multi-cycle mul/div sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ALUOp;
    logic [6:0] Funct7;
    logic [2:0] Funct3;
    logic       instr_valid;
    logic       flush;
    logic       div_by_zero;

    logic [3:0] op1, op0;
    logic       ill1, ill0;
    logic       start1, start0;
    logic [2:0] mdop1, mdop0;
    logic       busy1, busy0;
    logic       done1, done0;
    logic       dz1, dz0;
    logic       stall1, stall0;

    always #5 clk = ~clk;

    alu_seq_controller #(.EN_M(1), .MUL_LAT(4), .DIV_LAT(32)) u_dut1 (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7),
        .Funct3(Funct3), .instr_valid(instr_valid), .flush(flush),
        .div_by_zero(div_by_zero), .Operation(op1), .illegal(ill1),
        .md_start(start1), .md_op(mdop1), .md_busy(busy1), .md_done(done1),
        .md_dz(dz1), .stall(stall1)
    );

    alu_seq_controller #(.EN_M(0), .MUL_LAT(4), .DIV_LAT(32)) u_dut0 (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct7(Funct7),
        .Funct3(Funct3), .instr_valid(instr_valid), .flush(flush),
        .div_by_zero(div_by_zero), .Operation(op0), .illegal(ill0),
        .md_start(start0), .md_op(mdop0), .md_busy(busy0), .md_done(done0),
        .md_dz(dz0), .stall(stall0)
    );

    typedef struct packed {
        logic [1:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       valid;
        logic [3:0] exp_op;
        logic       exp_ill1;   // EN_M = 1 instance
        logic       exp_ill0;   // EN_M = 0 instance
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic [1:0] a, input logic [2:0] f3,
                                input logic [6:0] f7, input logic v,
                                input logic [3:0] op, input logic i1,
                                input logic i0);
        vec_t r;
        r.aluop = a; r.f3 = f3; r.f7 = f7; r.valid = v;
        r.exp_op = op; r.exp_ill1 = i1; r.exp_ill0 = i0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [1:0] a,
                          input logic [6:0] f7, input logic [2:0] f3,
                          input logic fl, input logic dz);
        instr_valid = v; ALUOp = a; Funct7 = f7; Funct3 = f3;
        flush = fl; div_by_zero = dz;
    endtask

    // Sequencer outputs of the EN_M=1 instance.
    task automatic chk_seq(input string tag, input logic st, input logic bz,
                           input logic dn, input logic dzv, input logic sl,
                           input logic [2:0] mop);
        chk({tag, ".md_start"}, {31'd0, start1}, {31'd0, st});
        chk({tag, ".md_busy"},  {31'd0, busy1},  {31'd0, bz});
        chk({tag, ".md_done"},  {31'd0, done1},  {31'd0, dn});
        chk({tag, ".md_dz"},    {31'd0, dz1},    {31'd0, dzv});
        chk({tag, ".stall"},    {31'd0, stall1}, {31'd0, sl});
        chk({tag, ".md_op"},    {29'd0, mdop1},  {29'd0, mop});
    endtask

    // Issue an M op (non-zero divisor) at the current cycle and follow it
    // through LAT busy cycles and the done cycle. Returns just after the
    // clock edge that follows the done cycle, with the op still driven.
    task automatic m_op(input logic [2:0] f3, input int lat);
        set_in(1'b1, 2'b10, 7'b0000001, f3, 1'b0, 1'b0);
        smp();
        chk_seq("m_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, f3);
        chk("en0.illegal",  {31'd0, ill0},   32'd1);
        chk("en0.md_start", {31'd0, start0}, 32'd0);
        chk("en0.stall",    {31'd0, stall0}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            nxt();
            smp();
            chk_seq("m_busy", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, f3);
        end
        nxt();
        smp();
        chk_seq("m_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, f3);
        nxt();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;

        // Decode vectors: {ALUOp, Funct3, Funct7, valid, Operation, ill(EN_M=1), ill(EN_M=0)}
        vq.push_back(mk(2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0110, 1'b0, 1'b0)); // SUB
        vq.push_back(mk(2'b01, 3'b110, 7'b0000000, 1'b1, 4'b1110, 1'b0, 1'b0)); // BLTU
        vq.push_back(mk(2'b11, 3'b101, 7'b0100000, 1'b1, 4'b0111, 1'b0, 1'b0)); // SRAI
        vq.push_back(mk(2'b01, 3'b010, 7'b0000000, 1'b1, 4'b0010, 1'b1, 1'b1)); // bad branch
        vq.push_back(mk(2'b01, 3'b011, 7'b0000000, 1'b0, 4'b0010, 1'b0, 1'b0)); // bad, not valid
        vq.push_back(mk(2'b00, 3'b011, 7'b1111111, 1'b1, 4'b0010, 1'b0, 1'b0)); // load/store
        vq.push_back(mk(2'b01, 3'b000, 7'b0000000, 1'b1, 4'b1000, 1'b0, 1'b0)); // BEQ
        vq.push_back(mk(2'b01, 3'b001, 7'b0000000, 1'b1, 4'b1001, 1'b0, 1'b0)); // BNE
        vq.push_back(mk(2'b01, 3'b100, 7'b0000000, 1'b1, 4'b1011, 1'b0, 1'b0)); // BLT
        vq.push_back(mk(2'b01, 3'b101, 7'b0000000, 1'b1, 4'b1010, 1'b0, 1'b0)); // BGE
        vq.push_back(mk(2'b01, 3'b111, 7'b0000000, 1'b1, 4'b1111, 1'b0, 1'b0)); // BGEU
        vq.push_back(mk(2'b10, 3'b000, 7'b0000000, 1'b1, 4'b0010, 1'b0, 1'b0)); // ADD
        vq.push_back(mk(2'b10, 3'b001, 7'b0000000, 1'b1, 4'b0100, 1'b0, 1'b0)); // SLL
        vq.push_back(mk(2'b10, 3'b010, 7'b0000000, 1'b1, 4'b1100, 1'b0, 1'b0)); // SLT
        vq.push_back(mk(2'b10, 3'b011, 7'b0000000, 1'b1, 4'b1101, 1'b0, 1'b0)); // SLTU
        vq.push_back(mk(2'b10, 3'b100, 7'b0000000, 1'b1, 4'b0011, 1'b0, 1'b0)); // XOR
        vq.push_back(mk(2'b10, 3'b101, 7'b0000000, 1'b1, 4'b0101, 1'b0, 1'b0)); // SRL
        vq.push_back(mk(2'b10, 3'b110, 7'b0000000, 1'b1, 4'b0001, 1'b0, 1'b0)); // OR
        vq.push_back(mk(2'b10, 3'b111, 7'b0000000, 1'b1, 4'b0000, 1'b0, 1'b0)); // AND
        vq.push_back(mk(2'b10, 3'b111, 7'b0100000, 1'b1, 4'b0010, 1'b1, 1'b1)); // bad f7
        vq.push_back(mk(2'b10, 3'b101, 7'b0000010, 1'b1, 4'b0010, 1'b1, 1'b1)); // bad shift f7
        vq.push_back(mk(2'b10, 3'b000, 7'b0000001, 1'b1, 4'b0010, 1'b0, 1'b1)); // MUL
        vq.push_back(mk(2'b11, 3'b000, 7'b1111111, 1'b1, 4'b0010, 1'b0, 1'b0)); // ADDI
        vq.push_back(mk(2'b11, 3'b001, 7'b0100000, 1'b1, 4'b0010, 1'b1, 1'b1)); // bad SLLI
        vq.push_back(mk(2'b11, 3'b001, 7'b0000000, 1'b1, 4'b0100, 1'b0, 1'b0)); // SLLI
        vq.push_back(mk(2'b11, 3'b010, 7'b0101010, 1'b1, 4'b1100, 1'b0, 1'b0)); // SLTI
        vq.push_back(mk(2'b11, 3'b011, 7'b0101010, 1'b1, 4'b1101, 1'b0, 1'b0)); // SLTIU
        vq.push_back(mk(2'b11, 3'b101, 7'b0000000, 1'b1, 4'b0101, 1'b0, 1'b0)); // SRLI
        vq.push_back(mk(2'b11, 3'b110, 7'b1000000, 1'b1, 4'b0001, 1'b0, 1'b0)); // ORI
        vq.push_back(mk(2'b11, 3'b000, 7'b0000001, 1'b1, 4'b0010, 1'b0, 1'b0)); // no M in I-type

        // Reset state
        reset = 1'b1;
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        nxt();
        nxt();
        smp();
        chk_seq("in_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        nxt();
        reset = 1'b0;
        smp();
        chk_seq("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        chk("post_reset.Operation", {28'd0, op1}, 32'h2);
        chk("post_reset.illegal",   {31'd0, ill1}, 32'd0);

        // Decode sweep; flush held high so M encodings never start the sequencer.
        foreach (vq[i]) begin
            nxt();
            set_in(vq[i].valid, vq[i].aluop, vq[i].f7, vq[i].f3, 1'b1, 1'b0);
            smp();
            chk($sformatf("vec%0d.Operation", i), {28'd0, op1}, {28'd0, vq[i].exp_op});
            chk($sformatf("vec%0d.illegal", i), {31'd0, ill1}, {31'd0, vq[i].exp_ill1});
            chk($sformatf("vec%0d.en0.Operation", i), {28'd0, op0}, {28'd0, vq[i].exp_op});
            chk($sformatf("vec%0d.en0.illegal", i), {31'd0, ill0}, {31'd0, vq[i].exp_ill0});
            chk($sformatf("vec%0d.md_start", i), {31'd0, start1}, 32'd0);
            chk($sformatf("vec%0d.stall", i), {31'd0, stall1}, 32'd0);
        end
        nxt();
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        smp();
        chk_seq("idle_pre_mul", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // MUL, full latency
        nxt();
        m_op(3'b000, 4);
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        smp();
        chk_seq("after_mul", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // DIVU by zero: one stall cycle, then done with md_dz
        nxt();
        set_in(1'b1, 2'b10, 7'b0000001, 3'b101, 1'b0, 1'b1);
        smp();
        chk_seq("dz_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b101);
        nxt();
        smp();
        chk_seq("dz_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b101);
        nxt();
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        smp();
        chk_seq("dz_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101);

        // DIV flushed in its 10th BUSY cycle
        nxt();
        set_in(1'b1, 2'b10, 7'b0000001, 3'b100, 1'b0, 1'b0);
        smp();
        chk_seq("div_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100);
        for (int k = 1; k <= 9; k++) begin
            nxt();
            smp();
            chk_seq("div_busy", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b100);
        end
        nxt();
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b1, 1'b0);
        smp();
        chk("flush_cycle.md_busy", {31'd0, busy1}, 32'd1);
        chk("flush_cycle.stall",   {31'd0, stall1}, 32'd0);
        chk("flush_cycle.md_done", {31'd0, done1}, 32'd0);
        nxt();
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        smp();
        chk_seq("after_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100);
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            nxt();
            smp();
            if (done1) done_cnt++;
        end
        chk("no_done_after_flush", 32'(done_cnt), 32'd0);

        // MULH with full latency, then MULHU back-to-back
        nxt();
        m_op(3'b001, 4);
        m_op(3'b011, 4);

        // REM with full divide latency
        m_op(3'b110, 32);

        // MULHSU interrupted by reset mid-BUSY
        set_in(1'b1, 2'b10, 7'b0000001, 3'b010, 1'b0, 1'b0);
        smp();
        chk_seq("rst_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010);
        nxt();
        smp();
        chk_seq("rst_busy", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'b010);
        nxt();
        reset = 1'b1;
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);
        smp();
        chk("reset_cycle.stall", {31'd0, stall1}, 32'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk_seq("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

        // EN_M=0 instance: M encoding is illegal and never sequenced
        nxt();
        set_in(1'b1, 2'b10, 7'b0000001, 3'b000, 1'b0, 1'b0);
        smp();
        chk("en0_m.illegal",   {31'd0, ill0},   32'd1);
        chk("en0_m.Operation", {28'd0, op0},    32'h2);
        chk("en0_m.stall",     {31'd0, stall0}, 32'd0);
        chk("en0_m.md_start",  {31'd0, start0}, 32'd0);
        nxt();
        smp();
        chk("en0_m.md_busy",   {31'd0, busy0},  32'd0);
        nxt();
        set_in(1'b0, 2'b00, 7'd0, 3'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
